// File: rtl/mini_src_datapath.sv
// Mini-SRC phase-1 single-bus datapath: 32-bit GPRs and special registers, a 64-bit Z and an ALU.
// Define ALU_MULDIV_EN to build the signed multiplier and divider.
module mini_src_reg32 (
   input  logic        clock,
   input  logic        clear,
   input  logic        load,
   input  logic [31:0] d,
   output logic [31:0] q
);

   // Bus-loaded register with asynchronous clear
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         q <= 32'h0;
      end else if (load) begin
         q <= d;
      end else begin
         q <= q;
      end
   end

endmodule

module mini_src_datapath (
   input  logic        clock,
   input  logic        clear,
   input  logic        R0in,  input logic R1in,  input logic R2in,  input logic R3in,
   input  logic        R4in,  input logic R5in,  input logic R6in,  input logic R7in,
   input  logic        R8in,  input logic R9in,  input logic R10in, input logic R11in,
   input  logic        R12in, input logic R13in, input logic R14in, input logic R15in,
   input  logic        HIin,
   input  logic        LOin,
   input  logic        Zhighin,
   input  logic        Zlowin,
   input  logic        PCin,
   input  logic        IRin,
   input  logic        MARin,
   input  logic        Yin,
   input  logic        In_Portin,
   input  logic        MDRin,
   input  logic        Read,
   input  logic        Zin,
   input  logic        Coutin,
   input  logic        R0out,  input logic R1out,  input logic R2out,  input logic R3out,
   input  logic        R4out,  input logic R5out,  input logic R6out,  input logic R7out,
   input  logic        R8out,  input logic R9out,  input logic R10out, input logic R11out,
   input  logic        R12out, input logic R13out, input logic R14out, input logic R15out,
   input  logic        HIout,
   input  logic        LOout,
   input  logic        Zhighout,
   input  logic        Zlowout,
   input  logic        PCout,
   input  logic        MDRout,
   input  logic        In_Portout,
   input  logic        Coutout,
   input  logic        IncPC,
   input  logic [31:0] Mdatain,
   input  logic [4:0]  ALU_Control,
   output logic [31:0] Out_Portout
);

   logic [31:0] bus_s;
   logic [31:0] gpr_q_s [16];
   logic [15:0] gpr_in_s;
   logic [23:0] out_sel_s;
   logic [31:0] src_s [24];
   logic [31:0] hi_q_s, lo_q_s, pc_q_s, ir_q_s, mar_q_s, mdr_q_s, y_q_s, inp_q_s;
   logic [31:0] mdr_d_s;
   logic [63:0] alu_c_s;
   logic [63:0] z_r;
   logic [4:0]  amt_s;
   logic        unused_s;

   assign gpr_in_s  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                       R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
   // Bit 0 is the highest-priority bus source
   assign out_sel_s = {Coutout, In_Portout, MDRout, PCout, Zlowout, Zhighout, LOout, HIout,
                       R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                       R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
   assign mdr_d_s   = Read ? Mdatain : bus_s;
   assign amt_s     = bus_s[4:0];
   assign Out_Portout = bus_s;

   mini_src_reg32 R0  (.clock(clock), .clear(clear), .load(gpr_in_s[0]),  .d(bus_s), .q(gpr_q_s[0]));
   mini_src_reg32 R1  (.clock(clock), .clear(clear), .load(gpr_in_s[1]),  .d(bus_s), .q(gpr_q_s[1]));
   mini_src_reg32 R2  (.clock(clock), .clear(clear), .load(gpr_in_s[2]),  .d(bus_s), .q(gpr_q_s[2]));
   mini_src_reg32 R3  (.clock(clock), .clear(clear), .load(gpr_in_s[3]),  .d(bus_s), .q(gpr_q_s[3]));
   mini_src_reg32 R4  (.clock(clock), .clear(clear), .load(gpr_in_s[4]),  .d(bus_s), .q(gpr_q_s[4]));
   mini_src_reg32 R5  (.clock(clock), .clear(clear), .load(gpr_in_s[5]),  .d(bus_s), .q(gpr_q_s[5]));
   mini_src_reg32 R6  (.clock(clock), .clear(clear), .load(gpr_in_s[6]),  .d(bus_s), .q(gpr_q_s[6]));
   mini_src_reg32 R7  (.clock(clock), .clear(clear), .load(gpr_in_s[7]),  .d(bus_s), .q(gpr_q_s[7]));
   mini_src_reg32 R8  (.clock(clock), .clear(clear), .load(gpr_in_s[8]),  .d(bus_s), .q(gpr_q_s[8]));
   mini_src_reg32 R9  (.clock(clock), .clear(clear), .load(gpr_in_s[9]),  .d(bus_s), .q(gpr_q_s[9]));
   mini_src_reg32 R10 (.clock(clock), .clear(clear), .load(gpr_in_s[10]), .d(bus_s), .q(gpr_q_s[10]));
   mini_src_reg32 R11 (.clock(clock), .clear(clear), .load(gpr_in_s[11]), .d(bus_s), .q(gpr_q_s[11]));
   mini_src_reg32 R12 (.clock(clock), .clear(clear), .load(gpr_in_s[12]), .d(bus_s), .q(gpr_q_s[12]));
   mini_src_reg32 R13 (.clock(clock), .clear(clear), .load(gpr_in_s[13]), .d(bus_s), .q(gpr_q_s[13]));
   mini_src_reg32 R14 (.clock(clock), .clear(clear), .load(gpr_in_s[14]), .d(bus_s), .q(gpr_q_s[14]));
   mini_src_reg32 R15 (.clock(clock), .clear(clear), .load(gpr_in_s[15]), .d(bus_s), .q(gpr_q_s[15]));

   mini_src_reg32 HI      (.clock(clock), .clear(clear), .load(HIin),      .d(bus_s),   .q(hi_q_s));
   mini_src_reg32 LO      (.clock(clock), .clear(clear), .load(LOin),      .d(bus_s),   .q(lo_q_s));
   mini_src_reg32 PC      (.clock(clock), .clear(clear), .load(PCin),      .d(bus_s),   .q(pc_q_s));
   mini_src_reg32 IR      (.clock(clock), .clear(clear), .load(IRin),      .d(bus_s),   .q(ir_q_s));
   mini_src_reg32 MAR     (.clock(clock), .clear(clear), .load(MARin),     .d(bus_s),   .q(mar_q_s));
   mini_src_reg32 Y       (.clock(clock), .clear(clear), .load(Yin),       .d(bus_s),   .q(y_q_s));
   mini_src_reg32 In_Port (.clock(clock), .clear(clear), .load(In_Portin), .d(bus_s),   .q(inp_q_s));
   mini_src_reg32 MDR     (.clock(clock), .clear(clear), .load(MDRin),     .d(mdr_d_s), .q(mdr_q_s));

   // Gather every bus source in priority order
   always_comb begin
      for (int i = 0; i < 16; i++) begin
         src_s[i] = gpr_q_s[i];
      end
      src_s[16] = hi_q_s;
      src_s[17] = lo_q_s;
      src_s[18] = z_r[63:32];
      src_s[19] = z_r[31:0];
      src_s[20] = pc_q_s;
      src_s[21] = mdr_q_s;
      src_s[22] = inp_q_s;
      src_s[23] = {{13{ir_q_s[18]}}, ir_q_s[18:0]};
   end

   // Bus mux: the lowest-index asserted select wins, none selected drives zero
   always_comb begin
      bus_s = 32'h0;
      for (int i = 23; i >= 0; i--) begin
         if (out_sel_s[i]) begin
            bus_s = src_s[i];
         end else begin
            bus_s = bus_s;
         end
      end
   end

`ifdef ALU_MULDIV_EN
   logic [63:0] mul_s;
   logic [32:0] quo_s;
   logic [32:0] rem_s;

   // Operands are widened one bit so the most-negative / -1 quotient cannot overflow
   assign mul_s = {{32{y_q_s[31]}}, y_q_s} * {{32{bus_s[31]}}, bus_s};
   assign quo_s = $signed({y_q_s[31], y_q_s}) / $signed({bus_s[31], bus_s});
   assign rem_s = $signed({y_q_s[31], y_q_s}) % $signed({bus_s[31], bus_s});
   assign unused_s = ^{Coutin, ir_q_s[31:19], mar_q_s, quo_s[32], rem_s[32]};
`else
   assign unused_s = ^{Coutin, ir_q_s[31:19], mar_q_s};
`endif

   // ALU: A comes from Y, B from the bus; IncPC overrides the opcode
   always_comb begin
      alu_c_s = 64'h0;
      if (IncPC) begin
         alu_c_s = {32'h0, bus_s + 32'd1};
      end else begin
         case (ALU_Control)
            5'b00000: alu_c_s = {32'h0, y_q_s + bus_s};
            5'b00001: alu_c_s = {32'h0, y_q_s - bus_s};
            5'b00010: alu_c_s = {32'h0, y_q_s & bus_s};
            5'b00011: alu_c_s = {32'h0, y_q_s | bus_s};
            5'b00100: alu_c_s = {32'h0, y_q_s >> amt_s};
            5'b00101: alu_c_s = {32'h0, $signed(y_q_s) >>> amt_s};
            5'b00110: alu_c_s = {32'h0, y_q_s << amt_s};
            5'b00111: alu_c_s = {32'h0, (y_q_s >> amt_s) | (y_q_s << (6'd32 - {1'b0, amt_s}))};
            5'b01000: alu_c_s = {32'h0, (y_q_s << amt_s) | (y_q_s >> (6'd32 - {1'b0, amt_s}))};
`ifdef ALU_MULDIV_EN
            5'b01001: alu_c_s = mul_s;
            5'b01010: begin
               if (bus_s == 32'h0) begin
                  alu_c_s = 64'h0;
               end else begin
                  alu_c_s = {rem_s[31:0], quo_s[31:0]};
               end
            end
`endif
            5'b01011: alu_c_s = {32'h0, 32'h0 - bus_s};
            5'b01100: alu_c_s = {32'h0, ~bus_s};
            default:  alu_c_s = 64'h0;
         endcase
      end
   end

   // Z: ALU load takes precedence over the half-word bus loads
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         z_r <= 64'h0;
      end else if (Zin) begin
         z_r <= alu_c_s;
      end else begin
         if (Zhighin) begin
            z_r[63:32] <= bus_s;
         end else begin
            z_r[63:32] <= z_r[63:32];
         end
         if (Zlowin) begin
            z_r[31:0] <= bus_s;
         end else begin
            z_r[31:0] <= z_r[31:0];
         end
      end
   end

endmodule

// File: tb/tb_mini_src_datapath.sv
// Self-checking bench for mini_src_datapath: directed T-state sequences with literal results,
// then random control words against a register-level model of the datapath.
module tb_mini_src_datapath;

   localparam int O_HI = 16, O_LO = 17, O_ZH = 18, O_ZL = 19, O_PC = 20, O_MDR = 21, O_INP = 22, O_C = 23;

   logic        clock = 1'b0;
   logic        clear;
   logic [15:0] rin;
   logic [23:0] outs;
   logic        HIin, LOin, Zhighin, Zlowin, PCin, IRin, MARin, Yin, In_Portin;
   logic        MDRin, Read, Zin, Coutin, IncPC;
   logic [31:0] Mdatain;
   logic [4:0]  ALU_Control;
   logic [31:0] Out_Portout;

   int n_checks = 0;
   int n_fail = 0;

   logic [31:0] m_gpr [16];
   logic [31:0] m_hi, m_lo, m_pc, m_ir, m_mar, m_mdr, m_y, m_inp;
   logic [63:0] m_z;

   always #5 clock = ~clock;

   mini_src_datapath DUT (
      .clock(clock), .clear(clear),
      .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]),
      .R4in(rin[4]), .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]),
      .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
      .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
      .HIin(HIin), .LOin(LOin), .Zhighin(Zhighin), .Zlowin(Zlowin), .PCin(PCin),
      .IRin(IRin), .MARin(MARin), .Yin(Yin), .In_Portin(In_Portin),
      .MDRin(MDRin), .Read(Read), .Zin(Zin), .Coutin(Coutin),
      .R0out(outs[0]), .R1out(outs[1]), .R2out(outs[2]), .R3out(outs[3]),
      .R4out(outs[4]), .R5out(outs[5]), .R6out(outs[6]), .R7out(outs[7]),
      .R8out(outs[8]), .R9out(outs[9]), .R10out(outs[10]), .R11out(outs[11]),
      .R12out(outs[12]), .R13out(outs[13]), .R14out(outs[14]), .R15out(outs[15]),
      .HIout(outs[O_HI]), .LOout(outs[O_LO]), .Zhighout(outs[O_ZH]), .Zlowout(outs[O_ZL]),
      .PCout(outs[O_PC]), .MDRout(outs[O_MDR]), .In_Portout(outs[O_INP]), .Coutout(outs[O_C]),
      .IncPC(IncPC), .Mdatain(Mdatain), .ALU_Control(ALU_Control), .Out_Portout(Out_Portout)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic idle();
      clear = 1'b0; rin = 16'h0; outs = 24'h0;
      HIin = 1'b0; LOin = 1'b0; Zhighin = 1'b0; Zlowin = 1'b0; PCin = 1'b0; IRin = 1'b0;
      MARin = 1'b0; Yin = 1'b0; In_Portin = 1'b0; MDRin = 1'b0; Read = 1'b0; Zin = 1'b0;
      Coutin = 1'b0; IncPC = 1'b0; Mdatain = 32'h0; ALU_Control = 5'd0;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 16; i++) m_gpr[i] = 32'h0;
      m_hi = 32'h0; m_lo = 32'h0; m_pc = 32'h0; m_ir = 32'h0; m_mar = 32'h0;
      m_mdr = 32'h0; m_y = 32'h0; m_inp = 32'h0; m_z = 64'h0;
   endtask

   function automatic logic [31:0] src_val(input int i);
      if (i < 16) return m_gpr[i];
      case (i)
         O_HI:    return m_hi;
         O_LO:    return m_lo;
         O_ZH:    return m_z[63:32];
         O_ZL:    return m_z[31:0];
         O_PC:    return m_pc;
         O_MDR:   return m_mdr;
         O_INP:   return m_inp;
         O_C:     return {{13{m_ir[18]}}, m_ir[18:0]};
         default: return 32'h0;
      endcase
   endfunction

   // First asserted source in the R0..R15,HI,LO,Zhigh,Zlow,PC,MDR,In_Port,C order owns the bus
   function automatic logic [31:0] model_bus();
      for (int i = 0; i < 24; i++) begin
         if (outs[i]) return src_val(i);
      end
      return 32'h0;
   endfunction

   function automatic logic [63:0] alu_model(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic inc);
      int n;
      logic signed [31:0] as_;
`ifdef ALU_MULDIV_EN
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
`endif
      n = int'(b[4:0]);
      as_ = a;
      if (inc) return {32'h0, b + 32'd1};
      case (op)
         5'd0:  return {32'h0, a + b};
         5'd1:  return {32'h0, a - b};
         5'd2:  return {32'h0, a & b};
         5'd3:  return {32'h0, a | b};
         5'd4:  return {32'h0, a >> n};
         5'd5:  return {32'h0, as_ >>> n};
         5'd6:  return {32'h0, a << n};
         5'd7:  return {32'h0, (n == 0) ? a : ((a >> n) | (a << (32 - n)))};
         5'd8:  return {32'h0, (n == 0) ? a : ((a << n) | (a >> (32 - n)))};
`ifdef ALU_MULDIV_EN
         5'd9:  return 64'(sa * sb);
         5'd10: begin
            if (b == 32'h0) return 64'h0;
            return {32'(sa % sb), 32'(sa / sb)};
         end
`endif
         5'd11: return {32'h0, 32'h0 - b};
         5'd12: return {32'h0, ~b};
         default: return 64'h0;
      endcase
   endfunction

   task automatic compare_state();
      for (int i = 0; i < 16; i++) chk($sformatf("R%0d", i), {32'h0, DUT.gpr_q_s[i]}, {32'h0, m_gpr[i]});
      chk("HI", {32'h0, DUT.HI.q}, {32'h0, m_hi});
      chk("LO", {32'h0, DUT.LO.q}, {32'h0, m_lo});
      chk("PC", {32'h0, DUT.PC.q}, {32'h0, m_pc});
      chk("IR", {32'h0, DUT.IR.q}, {32'h0, m_ir});
      chk("MAR", {32'h0, DUT.MAR.q}, {32'h0, m_mar});
      chk("MDR", {32'h0, DUT.MDR.q}, {32'h0, m_mdr});
      chk("Y", {32'h0, DUT.Y.q}, {32'h0, m_y});
      chk("In_Port", {32'h0, DUT.In_Port.q}, {32'h0, m_inp});
      chk("Z", DUT.z_r, m_z);
   endtask

   // One T-state: inputs are already driven just after a rising edge
   task automatic step();
      logic [31:0] b;
      logic [63:0] c;
      if (clear) model_clear();
      #1;
      b = model_bus();
      chk("bus", {32'h0, Out_Portout}, {32'h0, b});
      c = alu_model(ALU_Control, m_y, b, IncPC);
      @(posedge clock);
      if (!clear) begin
         for (int i = 0; i < 16; i++) if (rin[i]) m_gpr[i] = b;
         if (HIin) m_hi = b;
         if (LOin) m_lo = b;
         if (PCin) m_pc = b;
         if (IRin) m_ir = b;
         if (MARin) m_mar = b;
         if (Yin) m_y = b;
         if (In_Portin) m_inp = b;
         if (MDRin) m_mdr = Read ? Mdatain : b;
         if (Zin) m_z = c;
         else begin
            if (Zhighin) m_z[63:32] = b;
            if (Zlowin) m_z[31:0] = b;
         end
      end
      #1 compare_state();
   endtask

   task automatic load_mdr(input logic [31:0] v);
      idle(); Read = 1'b1; MDRin = 1'b1; Mdatain = v; step();
   endtask

   task automatic randomize_inputs();
      int sel;
      idle();
      clear = ($urandom_range(0, 49) == 0);
      rin = 16'($urandom & $urandom & $urandom);
      HIin = ($urandom_range(0, 5) == 0); LOin = ($urandom_range(0, 5) == 0);
      Zhighin = ($urandom_range(0, 5) == 0); Zlowin = ($urandom_range(0, 5) == 0);
      PCin = ($urandom_range(0, 5) == 0); IRin = ($urandom_range(0, 5) == 0);
      MARin = ($urandom_range(0, 5) == 0); Yin = ($urandom_range(0, 2) == 0);
      In_Portin = ($urandom_range(0, 5) == 0); MDRin = ($urandom_range(0, 2) == 0);
      Read = 1'($urandom_range(0, 1)); Zin = ($urandom_range(0, 2) == 0);
      Coutin = 1'($urandom_range(0, 1)); IncPC = ($urandom_range(0, 4) == 0);
      Mdatain = $urandom; ALU_Control = 5'($urandom_range(0, 15));
      sel = $urandom_range(0, 9);
      if (sel != 0) outs[$urandom_range(0, 23)] = 1'b1;
      if (sel == 1) outs[$urandom_range(0, 23)] = 1'b1;
   endtask

   initial begin
      idle();
      model_clear();
      #1 clear = 1'b1;
      #1;
      compare_state();
      chk("reset_bus", {32'h0, Out_Portout}, 64'h0);
      @(posedge clock);
      #1;

      load_mdr(32'h34);
      idle(); outs[O_MDR] = 1'b1; rin[5] = 1'b1; step();
      chk("R5_load", {32'h0, DUT.R5.q}, 64'h34);
      load_mdr(32'h45);
      idle(); outs[O_MDR] = 1'b1; rin[6] = 1'b1; step();
      chk("R6_load", {32'h0, DUT.R6.q}, 64'h45);

      idle(); outs[O_PC] = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; step();
      idle(); outs[O_ZL] = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; Mdatain = 32'h112B0000; step();
      idle(); outs[O_MDR] = 1'b1; IRin = 1'b1; step();
      chk("fetch_MAR", {32'h0, DUT.MAR.q}, 64'h0);
      chk("fetch_PC", {32'h0, DUT.PC.q}, 64'h1);
      chk("fetch_IR", {32'h0, DUT.IR.q}, 64'h112B0000);
      idle(); outs[O_C] = 1'b1;
      #1 chk("bus_C", {32'h0, Out_Portout}, 64'h00030000);
      step();

      idle(); outs[5] = 1'b1; Yin = 1'b1; step();
      idle(); outs[6] = 1'b1; ALU_Control = 5'd0; Zin = 1'b1; step();
      idle(); outs[O_ZL] = 1'b1; rin[2] = 1'b1; step();
      chk("ADD_R2", {32'h0, DUT.R2.q}, 64'h79);

      idle(); outs[6] = 1'b1; ALU_Control = 5'd1; Zin = 1'b1; step();
      chk("SUB_Z", DUT.z_r, 64'h00000000_FFFFFFEF);

      load_mdr(32'h1);
      idle(); outs[O_MDR] = 1'b1; Yin = 1'b1; step();
      idle(); outs[O_MDR] = 1'b1; ALU_Control = 5'd7; Zin = 1'b1; step();
      chk("ROR_Z", DUT.z_r, 64'h00000000_80000000);

      load_mdr(32'hFFFFFFFF);
      idle(); outs[O_MDR] = 1'b1; Yin = 1'b1; step();
      load_mdr(32'h2);
      idle(); outs[O_MDR] = 1'b1; ALU_Control = 5'd9; Zin = 1'b1; step();
`ifdef ALU_MULDIV_EN
      chk("MUL_Z", DUT.z_r, 64'hFFFFFFFF_FFFFFFFE);
`else
      chk("MUL_Z", DUT.z_r, 64'h0);
`endif

      idle(); IncPC = 1'b1; Zin = 1'b1;
      #1 chk("bus_idle", {32'h0, Out_Portout}, 64'h0);
      step();
      chk("IncPC_idle_bus", DUT.z_r, 64'h1);

      load_mdr(32'hA);
      idle(); outs[O_MDR] = 1'b1; rin[0] = 1'b1; step();
      idle(); outs[0] = 1'b1; outs[5] = 1'b1;
      #1 chk("bus_prio", {32'h0, Out_Portout}, 64'hA);
      step();

      idle(); outs[5] = 1'b1; Yin = 1'b1; step();
      idle(); outs[6] = 1'b1; ALU_Control = 5'd0; Zin = 1'b1;
      #2 clear = 1'b1;
      model_clear();
      @(posedge clock);
      #1;
      chk("clear_Z", DUT.z_r, 64'h0);
      compare_state();
      idle(); outs[O_ZL] = 1'b1; rin[2] = 1'b1; step();
      chk("clear_R2", {32'h0, DUT.R2.q}, 64'h0);

      for (int k = 0; k < 600; k++) begin
         randomize_inputs();
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
